// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// No logic; imported by the arbiter top and its request shadow.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2,
        ST_ACK   = 2'd3
    } dmem_state_t;

    localparam int         AW_DEFAULT = 8;
    localparam logic [3:0] LANE_ALL   = 4'hF;

endpackage

// File: rtl/dmem_req_shadow.sv
// Holds a debug request (we/addr/wdata) from acceptance until it is served.
// Loads on the edge where load=1, otherwise holds; no backpressure of its own.
module dmem_req_shadow
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          sysclk,
    input  logic          cpu_resetn,
    input  logic          load,
    input  logic          we_in,
    input  logic [AW-1:0] addr_in,
    input  logic [31:0]   wdata_in,
    output logic          we_q,
    output logic [AW-1:0] addr_q,
    output logic [31:0]   wdata_q
);

    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [31:0]   wdata_d;

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load) begin
            we_d    = we_in;
            addr_d  = addr_in;
            wdata_d = wdata_in;
        end
    end

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data memory between the execute stage (priority) and a debug port.
// Debug req->ack in 3..MAX_WAIT+3 cycles; a starved request forces a one-cycle cpu_stall.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int AW       = AW_DEFAULT
) (
    input  logic          sysclk,
    input  logic          cpu_resetn,
    input  logic          cpu_mem_req,
    input  logic [3:0]    cpu_wren,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wren,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   dbg_count
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    dmem_state_t   state_q, state_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          dbg_ack_q, dbg_ack_d;
    logic [31:0]   dbg_rdata_q, dbg_rdata_d;
    logic [15:0]   dbg_count_q, dbg_count_d;

    logic          sh_we;
    logic [AW-1:0] sh_addr;
    logic [31:0]   sh_wdata;
    logic          shadow_load;
    logic          dbg_own;
    logic [31:0]   dbg_capture;

    assign shadow_load = (state_q == ST_IDLE) && dbg_req;
    assign dbg_own     = (state_q == ST_FORCE) || ((state_q == ST_PEND) && !cpu_mem_req);
    // Async-read memory still shows the old word during a write, so writes echo their own data.
    assign dbg_capture = sh_we ? sh_wdata : mem_rdata;

    dmem_req_shadow #(.AW(AW)) u_shadow (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .load       (shadow_load),
        .we_in      (dbg_we),
        .addr_in    (dbg_addr),
        .wdata_in   (dbg_wdata),
        .we_q       (sh_we),
        .addr_q     (sh_addr),
        .wdata_q    (sh_wdata)
    );

    always_comb begin
        if (dbg_own) begin
            mem_addr  = sh_addr;
            mem_wren  = sh_we ? LANE_ALL : 4'h0;
            mem_wdata = sh_wdata;
        end else begin
            mem_addr  = cpu_addr;
            mem_wren  = cpu_mem_req ? cpu_wren : 4'h0;
            mem_wdata = cpu_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        dbg_ack_d   = 1'b0;
        dbg_rdata_d = dbg_rdata_q;
        dbg_count_d = dbg_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dbg_req) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (!cpu_mem_req) begin
                    state_d     = ST_ACK;
                    dbg_ack_d   = 1'b1;
                    dbg_rdata_d = dbg_capture;
                end else if (wait_cnt_q >= WAIT_LAST) begin
                    state_d = ST_FORCE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_FORCE: begin
                state_d     = ST_ACK;
                dbg_ack_d   = 1'b1;
                dbg_rdata_d = dbg_capture;
            end
            ST_ACK: begin
                state_d     = ST_IDLE;
                wait_cnt_d  = 8'd0;
                dbg_count_d = dbg_count_q + 16'd1;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 8'd0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= 32'd0;
            dbg_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_count_q <= dbg_count_d;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_stall = (state_q == ST_FORCE);
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_count = dbg_count_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of who owns memory each cycle and when debug is acked.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int AW       = 8;

    logic          sysclk = 1'b0;
    logic          cpu_resetn = 1'b0;
    logic          cpu_mem_req = 1'b0;
    logic [3:0]    cpu_wren = 4'h0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = 32'd0;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [31:0]   dbg_wdata = 32'd0;
    logic          dbg_ack;
    logic [31:0]   dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wren;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [15:0]   dbg_count;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
        .sysclk      (sysclk),
        .cpu_resetn  (cpu_resetn),
        .cpu_mem_req (cpu_mem_req),
        .cpu_wren    (cpu_wren),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .mem_addr    (mem_addr),
        .mem_wren    (mem_wren),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .dbg_count   (dbg_count)
    );

    always #5 sysclk = ~sysclk;

    // Data memory: combinational read, per-lane write on the clock edge.
    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'd0;
    logic [31:0] pl_data = 32'd0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge sysclk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            for (int l = 0; l < 4; l++)
                if (mem_wren[l]) mem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding debug transaction, served at the first
    // cycle the CPU leaves memory free or once it has been blocked MAX_WAIT times.
    logic [31:0] ref_mem [256];
    bit          m_out, m_ack_due, m_we;
    int          m_blk;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_rexp;
    logic [15:0] m_cnt;
    bit          last_ack, last_stall;

    task automatic model_step();
        bit serve, exp_stall;
        if (!cpu_resetn) begin
            m_out = 0; m_ack_due = 0; m_cnt = 16'd0; m_rexp = 32'd0; m_blk = 0;
            chk("rst_ack", dbg_ack, 1'b0);
            chk("rst_stall", cpu_stall, 1'b0);
            chk("rst_count", dbg_count, 16'd0);
            chk("rst_rdata", dbg_rdata, 32'd0);
            last_ack = dbg_ack; last_stall = cpu_stall;
            return;
        end
        exp_stall = m_out && (m_blk >= MAX_WAIT);
        serve     = m_out && (exp_stall || !cpu_mem_req);
        chk("stall", cpu_stall, exp_stall);
        chk("ack", dbg_ack, m_ack_due);
        chk("count", dbg_count, m_cnt);
        if (m_ack_due) chk("dbg_rdata", dbg_rdata, m_rexp);
        if (!serve && cpu_mem_req) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);

        if (serve) begin
            m_rexp = m_we ? m_wdata : ref_mem[m_addr];
            if (m_we) ref_mem[m_addr] = m_wdata;
        end else if (cpu_mem_req) begin
            for (int l = 0; l < 4; l++)
                if (cpu_wren[l]) ref_mem[cpu_addr][8*l +: 8] = cpu_wdata[8*l +: 8];
        end
        if (m_ack_due) m_cnt = m_cnt + 16'd1;
        if (!m_out && !m_ack_due && dbg_req) begin
            m_out = 1; m_blk = 0; m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata;
            m_ack_due = 0;
        end else begin
            m_ack_due = serve;
            if (serve) m_out = 0;
            else if (m_out) m_blk++;
        end
        last_ack = dbg_ack; last_stall = cpu_stall;
    endtask

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic tick();
        #1;
        model_step();
        @(negedge sysclk);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_ack && n < 40);
    endtask

    function automatic logic [31:0] pv(input int a);
        if (a == 'h10) return 32'h0000_0315;
        return 32'hA500_0000 + 32'(a) * 32'h0001_0101;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, stall_n, stall_at, ack_at, acks, pct;

        // Preload memory while held in reset.
        @(negedge sysclk);
        for (int a = 0; a < 256; a++) begin
            pl_en = 1'b1; pl_addr = 8'(a); pl_data = pv(a); ref_mem[a] = pv(a);
            @(negedge sysclk);
        end
        pl_en = 1'b0;
        tick();
        tick();
        cpu_resetn = 1'b1;

        // Idle debug read.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
        wait_ack(n);
        chk("idle_latency", n, 3);
        chk("idle_rdata", dbg_rdata, 32'h0000_0315);
        chk("idle_count", dbg_count, 16'd1);
        dbg_req = 1'b0;
        tick();

        // Debug write, then CPU load of the same word.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 32'hDEAD_BEEF;
        wait_ack(n);
        chk("wr_latency", n, 3);
        dbg_req = 1'b0;
        cpu_mem_req = 1'b1; cpu_wren = 4'h0; cpu_addr = 8'h20;
        #1 chk("cpu_load_after_dbg_wr", cpu_rdata, 32'hDEAD_BEEF);
        tick();

        // Starvation: CPU stores every cycle, debug read must be forced through.
        cpu_mem_req = 1'b1; cpu_wren = 4'hF; cpu_addr = 8'h30;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h40;
        stall_n = 0; stall_at = -1; ack_at = -1;
        for (int i = 0; i < 40 && ack_at < 0; i++) begin
            cpu_wdata = 32'h1000 + 32'(i);
            tick();
            if (last_stall) begin
                stall_n++; stall_at = i;
                chk("force_store_suppressed", mem[8'h30], 32'h1000 + 32'(i - 1));
            end
            if (last_ack) ack_at = i;
        end
        chk("force_stall_cycles", stall_n, 1);
        chk("force_stall_at", stall_at, MAX_WAIT + 1);
        chk("force_ack_at", ack_at, MAX_WAIT + 2);
        chk("force_rdata", dbg_rdata, pv('h40));
        dbg_req = 1'b0; cpu_mem_req = 1'b0;
        tick();

        // Collision: CPU and debug write the same word in the same cycle.
        cpu_mem_req = 1'b1; cpu_wren = 4'hF; cpu_addr = 8'h50; cpu_wdata = 32'h61;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h50; dbg_wdata = 32'h99;
        tick();
        tick();
        chk("coll_cpu_first", mem[8'h50], 32'h61);
        cpu_mem_req = 1'b0;
        tick();
        tick();
        chk("coll_ack", last_ack, 1'b1);
        chk("coll_final", mem[8'h50], 32'h99);
        dbg_req = 1'b0;
        tick();

        // Reset while a request is pending.
        cpu_mem_req = 1'b1; cpu_wren = 4'h0; cpu_addr = 8'h00;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h11;
        tick();
        tick();
        cpu_resetn = 1'b0; dbg_req = 1'b0; cpu_mem_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            acks += int'(last_ack);
        end
        cpu_resetn = 1'b1;
        tick();
        acks += int'(last_ack);
        chk("rst_no_ack", acks, 0);
        chk("rst_count_zero", dbg_count, 16'd0);
        dbg_req = 1'b1;
        wait_ack(n);
        chk("rst_fresh_latency", n, 3);
        chk("rst_fresh_rdata", dbg_rdata, pv('h11));
        dbg_req = 1'b0;
        tick();

        // Counter wrap via backdoor preset.
        force dut.dbg_count_q = 16'hFFFF;
        #1 release dut.dbg_count_q;
        m_cnt = 16'hFFFF;
        chk("wrap_preset", dbg_count, 16'hFFFF);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h05;
        wait_ack(n);
        chk("wrap_count", dbg_count, 16'd0);
        dbg_req = 1'b0;
        tick();

        // Random traffic with varying CPU load.
        pct = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) pct = 40 + 20 * int'($urandom_range(0, 2)) + 15;
            cpu_mem_req = ($urandom_range(0, 99) < pct);
            cpu_wren    = 4'($urandom_range(0, 15));
            cpu_addr    = 8'($urandom_range(0, 15));
            cpu_wdata   = $urandom();
            if (last_ack) begin
                dbg_req = 1'b0;
            end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = 8'($urandom_range(0, 15));
                dbg_wdata = $urandom();
            end
            tick();
        end
        cpu_mem_req = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (last_ack) dbg_req = 1'b0;
            tick();
        end
        dbg_req = 1'b0;
        tick();
        for (int a = 0; a < 256; a++) chk("mem_final", mem[a], ref_mem[a]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
